// File: rtl/i_ddr_bus.sv
// Purpose: multi-channel DDR input register; pairs rise/fall samples per channel, with phase slip and fill-based valid.
// Latency: rising-edge sample to Q in 1 posedge (PIPE=0) or 2 posedges (PIPE=1).
// Backpressure: none; E=0 freezes the pair register while capture, fill counter and slip keep running.
module i_ddr_bus #(
    parameter int WIDTH = 4,
    parameter int PIPE  = 0
) (
    input  logic               C,
    input  logic               R,
    input  logic [WIDTH-1:0]   D,
    input  logic               E,
    input  logic               SLIP,
    output logic [2*WIDTH-1:0] Q,
    output logic               VLD,
    output logic               PHASE
);

    logic [WIDTH-1:0]   pos;
    logic [WIDTH-1:0]   neg;
    logic [WIDTH-1:0]   neg_d;
    logic [1:0]         cnt;
    logic [2*WIDTH-1:0] q1;
    logic [2*WIDTH-1:0] pair;
    logic               v1;
    logic               slip_acc;

    // A slip is honoured only once the capture pipeline has refilled since the last reset or slip
    assign slip_acc = SLIP && (cnt == 2'd2);

    // Interleave samples per channel; the odd bit always carries the earlier sample
    always_comb begin
        pair = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (PHASE) begin
                pair[2*i+1] = neg_d[i];
                pair[2*i]   = pos[i];
            end else begin
                pair[2*i+1] = pos[i];
                pair[2*i]   = neg[i];
            end
        end
    end

    // Falling-edge capture
    always_ff @(negedge C or negedge R) begin
        if (!R) begin
            neg <= '0;
        end else begin
            neg <= D;
        end
    end

    // Rising-edge capture, fill counter, phase control and pair register
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            pos   <= '0;
            neg_d <= '0;
            cnt   <= 2'd0;
            PHASE <= 1'b0;
            q1    <= '0;
            v1    <= 1'b0;
        end else begin
            pos   <= D;
            neg_d <= neg;
            if (slip_acc) begin
                cnt   <= 2'd0;
                PHASE <= ~PHASE;
            end else if (cnt != 2'd2) begin
                cnt <= cnt + 2'd1;
            end
            // The pair loaded at a slip still uses the old phase; valid is dropped regardless of E
            if (E) begin
                q1 <= pair;
            end
            if (slip_acc) begin
                v1 <= 1'b0;
            end else if (E) begin
                v1 <= (cnt == 2'd2);
            end
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            // Unconditional output retiming stage
            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    Q   <= '0;
                    VLD <= 1'b0;
                end else begin
                    Q   <= q1;
                    VLD <= v1;
                end
            end
        end else begin : g_nopipe
            assign Q   = q1;
            assign VLD = v1;
        end
    endgenerate

endmodule

// File: tb/tb_i_ddr_bus.sv
module tb_i_ddr_bus;

    typedef struct packed {
        logic       vld;
        logic [7:0] q;
        logic       ph;
        logic       chk;
    } exp_t;

    logic       C;
    logic       R;
    logic [3:0] D;
    logic       E;
    logic       SLIP;
    logic [7:0] q_p0;
    logic [7:0] q_p1;
    logic       vld_p0;
    logic       vld_p1;
    logic       ph_p0;
    logic       ph_p1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0_exp[$];
    exp_t q1_exp[$];
    exp_t prev;

    i_ddr_bus #(.WIDTH(4), .PIPE(0)) dut0 (
        .C(C), .R(R), .D(D), .E(E), .SLIP(SLIP),
        .Q(q_p0), .VLD(vld_p0), .PHASE(ph_p0)
    );

    i_ddr_bus #(.WIDTH(4), .PIPE(1)) dut1 (
        .C(C), .R(R), .D(D), .E(E), .SLIP(SLIP),
        .Q(q_p1), .VLD(vld_p1), .PHASE(ph_p1)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor for PIPE=0 instance
    initial begin
        exp_t e;
        forever begin
            @(posedge C);
            #1;
            if (q0_exp.size() > 0) begin
                e = q0_exp.pop_front();
                check("p0_vld", {31'd0, vld_p0}, {31'd0, e.vld});
                check("p0_phase", {31'd0, ph_p0}, {31'd0, e.ph});
                if (e.chk) check("p0_q", {24'd0, q_p0}, {24'd0, e.q});
            end
        end
    end

    // Monitor for PIPE=1 instance
    initial begin
        exp_t e;
        forever begin
            @(posedge C);
            #1;
            if (q1_exp.size() > 0) begin
                e = q1_exp.pop_front();
                check("p1_vld", {31'd0, vld_p1}, {31'd0, e.vld});
                check("p1_phase", {31'd0, ph_p1}, {31'd0, e.ph});
                if (e.chk) check("p1_q", {24'd0, q_p1}, {24'd0, e.q});
            end
        end
    end

    // One posedge: f is sampled at the negedge before it, r at the posedge itself.
    // Expected values are for the PIPE=0 instance; the PIPE=1 instance sees the previous Q/VLD.
    task automatic row(input logic e, input logic s, input logic [3:0] r, input logic [3:0] f,
                       input logic ev, input logic [7:0] eq, input logic ep, input logic ec);
        exp_t cur;
        exp_t dly;
        E    = e;
        SLIP = s;
        D    = f;
        cur  = '{vld: ev, q: eq, ph: ep, chk: ec};
        dly  = '{vld: prev.vld, q: prev.q, ph: ep, chk: prev.chk};
        q0_exp.push_back(cur);
        q1_exp.push_back(dly);
        prev = cur;
        @(negedge C);
        #2 D = r;
        @(posedge C);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q0"}, {24'd0, q_p0}, 32'd0);
        check({tag, "_vld0"}, {31'd0, vld_p0}, 32'd0);
        check({tag, "_ph0"}, {31'd0, ph_p0}, 32'd0);
        check({tag, "_q1"}, {24'd0, q_p1}, 32'd0);
        check({tag, "_vld1"}, {31'd0, vld_p1}, 32'd0);
        check({tag, "_ph1"}, {31'd0, ph_p1}, 32'd0);
    endtask

    initial begin
        R    = 1'b0;
        E    = 1'b0;
        SLIP = 1'b0;
        D    = 4'h0;
        prev = '{vld: 1'b0, q: 8'h00, ph: 1'b0, chk: 1'b1};
        repeat (3) @(posedge C);
        #2;
        check_reset_outputs("reset");
        R = 1'b1;

        // Fill from reset, toggling rise=1 / fall=0
        row(1, 0, 4'hF, 4'h0, 0, 8'h00, 0, 1);
        row(1, 0, 4'hF, 4'h0, 0, 8'hAA, 0, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'hAA, 0, 1);
        // Slip accept (old phase used for this load), then lockout slip ignored
        row(1, 1, 4'hF, 4'h0, 0, 8'hAA, 1, 1);
        row(1, 1, 4'hF, 4'h0, 0, 8'h55, 1, 1);
        row(1, 0, 4'hF, 4'h0, 0, 8'h55, 1, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'h55, 1, 1);
        // Distinct lane data in phase 1: f=1010, r=1100
        row(1, 0, 4'hC, 4'hA, 1, 8'h55, 1, 1);
        row(1, 0, 4'hC, 4'hA, 1, 8'hD8, 1, 1);
        // E low for 4 cycles with changing data: hold
        row(0, 0, 4'h3, 4'h5, 1, 8'hD8, 1, 1);
        row(0, 0, 4'h6, 4'h9, 1, 8'hD8, 1, 1);
        row(0, 0, 4'h0, 4'hF, 1, 8'hD8, 1, 1);
        row(0, 0, 4'h9, 4'h6, 1, 8'hD8, 1, 1);
        // E back high: current pair (f=0110, r=1001), no stale data
        row(1, 0, 4'hF, 4'h0, 1, 8'h69, 1, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'h55, 1, 1);
        // Slip with E low: phase back to 0, valid dropped, Q held
        row(0, 1, 4'hF, 4'h0, 0, 8'h55, 0, 1);
        row(1, 0, 4'hC, 4'hA, 0, 8'hEE, 0, 1);
        row(1, 0, 4'hC, 4'hA, 0, 8'hE4, 0, 1);
        row(1, 0, 4'hC, 4'hA, 1, 8'hE4, 0, 1);
        // Slip to phase 1 and refill before the mid-run reset
        row(1, 1, 4'hF, 4'h0, 0, 8'hA0, 1, 1);
        row(1, 0, 4'hF, 4'h0, 0, 8'h55, 1, 1);
        row(1, 0, 4'hF, 4'h0, 0, 8'h55, 1, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'h55, 1, 1);

        // Asynchronous reset between edges with VLD=1, PHASE=1
        #1 R = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        R    = 1'b1;
        prev = '{vld: 1'b0, q: 8'h00, ph: 1'b0, chk: 1'b1};

        // Full fill sequence restarts
        row(1, 0, 4'hF, 4'h0, 0, 8'h00, 0, 1);
        row(1, 0, 4'hF, 4'h0, 0, 8'hAA, 0, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'hAA, 0, 1);
        row(1, 0, 4'hF, 4'h0, 1, 8'hAA, 0, 1);

        @(posedge C);
        #3;
        check("q0_drained", q0_exp.size(), 32'd0);
        check("q1_drained", q1_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
